divider_4bit_seq: RTL and testbench
===================================

# divider_4bit_seq

- Sequential 4-bit unsigned restoring divider: computes quotient and remainder of X ÷ Y, one quotient bit per clock.
- Each iteration is a trial subtraction using the same borrow convention as the lab's adder/subtractor: carry-out 1 means no borrow.
- Sits beside the 4-bit adder/subtractor in the lab datapath as its inverse arithmetic unit, with a start/busy/done handshake toward the controlling logic.

## Interface
- No parameters; width fixed at 4 bits.
- Clk  in  1  rising-edge clock (only clock)
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request pulse; sampled only when not Busy
- X  in  4  dividend (unsigned), captured on accepted Start
- Y  in  4  divisor (unsigned), captured on accepted Start
- Q  out  4  quotient register
- R  out  4  remainder register
- Busy  out  1  high while iterating
- Done  out  1  one-cycle pulse: Q/R/DivZ valid
- DivZ  out  1  divide-by-zero flag for the last completed operation

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - 5-bit partial remainder P
  - 4-bit shift register A (dividend/quotient)
  - 4-bit divisor copy D
  - 2-bit iteration counter
- IDLE or DONE with Start=1 and Y≠0:
  - Capture A←X, D←Y, P←0, counter←3.
  - Clear DivZ; go to RUN.
- IDLE or DONE with Start=1 and Y=0:
  - No iterations.
  - Q←4'hF, R←X, DivZ←1; go to DONE.
- IDLE or DONE with Start=0: DONE→IDLE; IDLE stays.
- RUN iteration, one per clock:
  - S = {P[3:0], A[3]} (5 bits).
  - T = S − {0, D}, computed as S + ~{0, D} + 1 over 5 bits; no-borrow = carry-out.
  - If no-borrow: P←T, A←{A[2:0], 1}.
  - Else: P←S, A←{A[2:0], 0}.
- RUN exit:
  - After the iteration with counter=0: Q←A (updated), R←P[3:0], go to DONE.
  - Otherwise decrement the counter.
- Arithmetic invariants:
  - P < D after every iteration, so P[4]=0 at completion.
  - Result always satisfies X = Q·Y + R with R < Y for Y≠0.
- Q, R and DivZ hold their values from DONE until the next accepted Start (Y≠0 case: Q/R unchanged until RUN exit).
- Start while in RUN is ignored; operands are not re-captured.
- Inputs X/Y may change freely after the accepting edge.

## Timing
- Reset (any state, including mid-RUN) at a clock edge: state←IDLE, Q=0, R=0, Busy=0, Done=0, DivZ=0. Any in-flight operation is discarded with no Done.
- Reset has priority over Start in the same cycle.
- Busy = (state==RUN); Done = (state==DONE). Both are registered-state decodes, glitch-free at the cycle boundary.
- Normal operation (Start accepted at edge k):
  - Busy=1 for the cycles after edges k..k+3.
  - Edge k+4 enters DONE: Done=1 for exactly one cycle, Q/R valid in that same cycle.
  - Latency is 5 edges, start to Done.
- Divide by zero (Start accepted at edge k): Done=1 with DivZ=1 in the cycle after edge k; Busy never asserts.
- Back-to-back: Start high during the Done cycle is accepted at the next edge, giving the same timing as from IDLE. Throughput is one operation per 5 cycles.
- Start held high continuously: re-accepted at every DONE, giving back-to-back operations on current X/Y.

## Test plan
- X=13, Y=4, one-cycle Start → Busy for 4 cycles; Done at 5th edge with Q=3, R=1, DivZ=0. Done drops next cycle; Q/R hold.
- X=15, Y=1 → Q=15, R=0. X=3, Y=9 → Q=0, R=3. X=15, Y=15 → Q=1, R=0. Exhaustive sweep of all 256 X/Y pairs checks X=Q·Y+R, R<Y, and DivZ only when Y=0.
- X=7, Y=0 → Busy stays 0; Done one cycle after Start, with DivZ=1, Q=4'hF, R=7. Next op X=9, Y=2 clears DivZ and gives Q=4, R=1.
- X=14, Y=3 started; Start pulsed again mid-RUN with X=1, Y=1 → ignored; Done at edge k+4 with Q=4, R=2.
- Reset asserted 2 cycles into RUN → next cycle all outputs 0, state IDLE, no Done pulse. A subsequent X=10, Y=5 gives Q=2, R=0.
- Start asserted in the Done cycle of X=9, Y=3 (Q=3, R=0) with new X=8, Y=3 → no IDLE gap; second Done exactly 5 edges later with Q=2, R=2.

Source files
------------

// File: rtl/divider_4bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_4bit_seq
// Brief    : 4-bit unsigned restoring divider, one quotient bit per clock,
//            with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module divider_4bit_seq (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       Busy,
    output logic       Done,
    output logic       DivZ
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0] r_state;
    logic [4:0] r_p;
    logic [3:0] r_a;
    logic [3:0] r_d;
    logic [1:0] r_cnt;
    logic [3:0] r_q;
    logic [3:0] r_r;
    logic       r_divz;

    logic [1:0] w_state_nxt;
    logic [4:0] w_p_nxt;
    logic [3:0] w_a_nxt;
    logic [3:0] w_d_nxt;
    logic [1:0] w_cnt_nxt;
    logic [3:0] w_q_nxt;
    logic [3:0] w_r_nxt;
    logic       w_divz_nxt;

    logic [4:0] w_s;
    logic [5:0] w_sum;
    logic       w_no_borrow;
    logic [4:0] w_p_iter;
    logic [3:0] w_a_iter;
    logic       w_unused;

    // Trial subtraction in the adder/subtractor style: carry-out set means no borrow.
    assign w_s         = {r_p[3:0], r_a[3]};
    assign w_sum       = {1'b0, w_s} + {1'b0, ~{1'b0, r_d}} + 6'd1;
    assign w_no_borrow = w_sum[5];
    assign w_p_iter    = w_no_borrow ? w_sum[4:0] : w_s;
    assign w_a_iter    = {r_a[2:0], w_no_borrow};

    // P stays below D, so its top bit never feeds the next shift.
    assign w_unused    = r_p[4];

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_a_nxt     = r_a;
        w_d_nxt     = r_d;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_divz_nxt  = r_divz;

        case (r_state)
            c_st_idle, c_st_done: begin
                if (Start) begin
                    if (Y != 4'd0) begin
                        w_a_nxt     = X;
                        w_d_nxt     = Y;
                        w_p_nxt     = 5'd0;
                        w_cnt_nxt   = 2'd3;
                        w_divz_nxt  = 1'b0;
                        w_state_nxt = c_st_run;
                    end else begin
                        w_q_nxt     = 4'hF;
                        w_r_nxt     = X;
                        w_divz_nxt  = 1'b1;
                        w_state_nxt = c_st_done;
                    end
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_run: begin
                w_p_nxt = w_p_iter;
                w_a_nxt = w_a_iter;
                if (r_cnt == 2'd0) begin
                    w_q_nxt     = w_a_iter;
                    w_r_nxt     = w_p_iter[3:0];
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_st_idle;
            r_p     <= 5'd0;
            r_a     <= 4'd0;
            r_d     <= 4'd0;
            r_cnt   <= 2'd0;
            r_q     <= 4'd0;
            r_r     <= 4'd0;
            r_divz  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_a     <= w_a_nxt;
            r_d     <= w_d_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_divz  <= w_divz_nxt;
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign DivZ = r_divz;
    assign Busy = (r_state == c_st_run);
    assign Done = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_divider_4bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_4bit_seq
// Brief    : Self-checking bench for divider_4bit_seq against an arithmetic
//            reference (integer / and %).
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_4bit_seq;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] X = 4'd0;
    logic [3:0] Y = 4'd0;
    logic [3:0] Q;
    logic [3:0] R;
    logic       Busy;
    logic       Done;
    logic       DivZ;

    int checks = 0;
    int errors = 0;

    divider_4bit_seq dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .X     (X),
        .Y     (Y),
        .Q     (Q),
        .R     (R),
        .Busy  (Busy),
        .Done  (Done),
        .DivZ  (DivZ)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] ref_q(input int x, input int y);
        return (y == 0) ? 4'hF : 4'(x / y);
    endfunction

    function automatic logic [3:0] ref_r(input int x, input int y);
        return (y == 0) ? 4'(x) : 4'(x % y);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Launches one operation from the current cycle and stops in the Done cycle.
    task automatic do_op(input logic [3:0] x, input logic [3:0] y,
                         output int lat, output int busy_cnt);
        Start = 1'b1;
        X = x;
        Y = y;
        tick();
        Start = 1'b0;
        X = 4'($urandom);
        Y = 4'($urandom);
        lat = 1;
        busy_cnt = Busy ? 1 : 0;
        while (!Done && lat < 12) begin
            tick();
            lat++;
            if (Busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        X = 4'd5;
        Y = 4'd0;
        tick();
        tick();
        checks++;
        if ({Q, R, Busy, Done, DivZ} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got Q=%0d R=%0d Busy=%0b Done=%0b DivZ=%0b, want all 0", Q, R, Busy, Done, DivZ);
        end
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        checks++;
        if ({Busy, Done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got Busy=%0b Done=%0b, want 0 0", Busy, Done);
        end
    endtask

    task automatic test_directed();
        logic [3:0] xs [4] = '{4'd13, 4'd15, 4'd3, 4'd15};
        logic [3:0] ys [4] = '{4'd4, 4'd1, 4'd9, 4'd15};
        logic [3:0] eq [4] = '{4'd3, 4'd15, 4'd0, 4'd1};
        logic [3:0] er [4] = '{4'd1, 4'd0, 4'd3, 4'd0};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            do_op(xs[i], ys[i], lat, bc);
            checks++;
            if (lat != 5 || bc != 4 || Done !== 1'b1) begin
                errors++;
                $display("FAIL directed_timing %0d/%0d: got lat=%0d busy=%0d done=%0b, want 5 4 1", xs[i], ys[i], lat, bc, Done);
            end
            checks++;
            if (Q !== eq[i] || R !== er[i] || DivZ !== 1'b0) begin
                errors++;
                $display("FAIL directed_result %0d/%0d: got Q=%0d R=%0d DivZ=%0b, want Q=%0d R=%0d DivZ=0", xs[i], ys[i], Q, R, DivZ, eq[i], er[i]);
            end
            if (i == 0) begin
                tick();
                checks++;
                if (Done !== 1'b0 || Q !== 4'd3 || R !== 4'd1) begin
                    errors++;
                    $display("FAIL done_pulse_hold: got Done=%0b Q=%0d R=%0d, want 0 3 1", Done, Q, R);
                end
            end
        end
        tick();
    endtask

    task automatic test_divz();
        int lat, bc;
        do_op(4'd7, 4'd0, lat, bc);
        checks++;
        if (lat != 1 || bc != 0 || Q !== 4'hF || R !== 4'd7 || DivZ !== 1'b1) begin
            errors++;
            $display("FAIL divz: got lat=%0d busy=%0d Q=%0d R=%0d DivZ=%0b, want 1 0 15 7 1", lat, bc, Q, R, DivZ);
        end
        do_op(4'd9, 4'd2, lat, bc);
        checks++;
        if (lat != 5 || Q !== 4'd4 || R !== 4'd1 || DivZ !== 1'b0) begin
            errors++;
            $display("FAIL divz_clear: got lat=%0d Q=%0d R=%0d DivZ=%0b, want 5 4 1 0", lat, Q, R, DivZ);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        Start = 1'b1;
        X = 4'd14;
        Y = 4'd3;
        tick();
        Start = 1'b0;
        tick();
        Start = 1'b1;
        X = 4'd1;
        Y = 4'd1;
        tick();
        Start = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL ignored_midrun: got Busy=%0b Done=%0b at k+3, want 1 0", Busy, Done);
        end
        tick();
        checks++;
        if (Done !== 1'b1 || Q !== 4'd4 || R !== 4'd2) begin
            errors++;
            $display("FAIL ignored_result: got Done=%0b Q=%0d R=%0d, want 1 4 2", Done, Q, R);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        bit seen_done;
        Start = 1'b1;
        X = 4'd13;
        Y = 4'd4;
        tick();
        Start = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if ({Q, R, Busy, Done, DivZ} !== 11'd0) begin
            errors++;
            $display("FAIL reset_midrun: got Q=%0d R=%0d Busy=%0b Done=%0b DivZ=%0b, want all 0", Q, R, Busy, Done, DivZ);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Done || Busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL reset_discard: got activity after reset, want none");
        end
        do_op(4'd10, 4'd5, lat, bc);
        checks++;
        if (lat != 5 || Q !== 4'd2 || R !== 4'd0) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d Q=%0d R=%0d, want 5 2 0", lat, Q, R);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_op(4'd9, 4'd3, lat, bc);
        checks++;
        if (lat != 5 || Q !== 4'd3 || R !== 4'd0) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d Q=%0d R=%0d, want 5 3 0", lat, Q, R);
        end
        do_op(4'd8, 4'd3, lat, bc);
        checks++;
        if (lat != 5 || bc != 4 || Q !== 4'd2 || R !== 4'd2) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d busy=%0d Q=%0d R=%0d, want 5 4 2 2", lat, bc, Q, R);
        end
        tick();
    endtask

    task automatic test_held_start();
        int dones = 0;
        Start = 1'b1;
        X = 4'd11;
        Y = 4'd2;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (Done) dones++;
        end
        checks++;
        if (dones != 3 || Done !== 1'b1 || Q !== 4'd5 || R !== 4'd1) begin
            errors++;
            $display("FAIL held_start: got dones=%0d Done=%0b Q=%0d R=%0d, want 3 1 5 1", dones, Done, Q, R);
        end
        Start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int lat, bc, x, y;
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 15));
            y = int'($urandom_range(0, 15));
            do_op(4'(x), 4'(y), lat, bc);
            checks++;
            if (lat != ((y == 0) ? 1 : 5) || Q !== ref_q(x, y) || R !== ref_r(x, y) || DivZ !== (y == 0)) begin
                errors++;
                $display("FAIL random %0d/%0d: got lat=%0d Q=%0d R=%0d DivZ=%0b, want lat=%0d Q=%0d R=%0d", x, y, lat, Q, R, DivZ, (y == 0) ? 1 : 5, ref_q(x, y), ref_r(x, y));
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_exhaustive();
        int lat, bc;
        int bad = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_op(4'(x), 4'(y), lat, bc);
                if (y != 0) begin
                    if (int'(Q) * y + int'(R) != x || int'(R) >= y || DivZ !== 1'b0 || Done !== 1'b1) begin
                        bad++;
                        $display("FAIL sweep %0d/%0d: got Q=%0d R=%0d DivZ=%0b", x, y, Q, R, DivZ);
                    end
                end else if (DivZ !== 1'b1 || Done !== 1'b1) begin
                    bad++;
                    $display("FAIL sweep %0d/0: got DivZ=%0b Done=%0b, want 1 1", x, DivZ, Done);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sweep_total: got %0d bad pairs, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_divz();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_held_start();
        test_random();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
